// File: rtl/mmio_pkg.sv
// Shared address map, default event mask and range helpers for the MMIO bank.
package mmio_pkg;

   localparam int KEYPAD_ADDR      = 0;
   localparam int BEAM_BASE        = 1;
   localparam int SERVO_BACK_BASE  = 5;
   localparam int SERVO_FRONT_BASE = 9;
   localparam int LED14_ADDR       = 16;
   localparam int LED15_ADDR       = 17;
   localparam int SEG_BASE         = 18;
   localparam int SERVO_BASE       = 23;
   localparam int STATE_LED_BASE   = 28;

   // Keypad is a synchronous level; beams and servo feedback are event channels.
   localparam logic [12:0] DEF_EVENT_MASK = 13'h1FFE;
   localparam int          DEF_RAM_BASE   = 64;

   function automatic bit ranges_overlap(int b0, int n0, int b1, int n1);
      return (b0 < b1 + n1) && (b1 < b0 + n0);
   endfunction

endpackage

// File: rtl/mmio_event_capture.sv
// One event channel: 2-FF synchroniser, rising-edge detect and sticky pending flag.
// Clear is write-1-to-clear; a simultaneous new edge keeps the flag set.
module mmio_event_capture (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   input  logic clr,
   output logic level,
   output logic pending
);

   logic sync1;
   logic sync2;
   logic prev;
   logic rise;

   assign rise  = sync2 & ~prev;
   assign level = sync2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         prev    <= sync2;
         pending <= rise | (pending & ~clr);
      end
   end

endmodule

// File: rtl/mmio_bank.sv
// Memory-mapped I/O bank: input channels (plain or edge-captured), output registers with
// write strobes, RAM pass-through. Define MMIO_BANK_IRQ_EN for the irq output and enable register.
module mmio_bank
   import mmio_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 12,
   parameter int                N_IN       = 13,
   parameter int                N_OUT      = 16,
   parameter int                IN_BASE    = 0,
   parameter int                OUT_BASE   = 16,
   parameter int                RAM_BASE   = DEF_RAM_BASE,
   parameter logic [N_IN-1:0]   EVENT_MASK = N_IN'(DEF_EVENT_MASK),
   parameter logic [DATA_W-1:0] OUT_RST    = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       addr,
   input  logic                    wren,
   input  logic [DATA_W-1:0]       wdata,
   input  logic [DATA_W-1:0]       ram_rdata,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    ram_sel,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   output logic [N_OUT*DATA_W-1:0] out_regs,
`ifdef MMIO_BANK_IRQ_EN
   output logic                    irq,
`endif
   output logic [N_OUT-1:0]        out_strobe
);

`ifdef MMIO_BANK_IRQ_EN
   localparam int OUT_SPAN = N_OUT + 1;
`else
   localparam int OUT_SPAN = N_OUT;
`endif
   localparam int RAM_SPAN = (1 << ADDR_W) - RAM_BASE;

   if (N_IN > 32 || N_OUT > 32) begin : g_size_err
      $error("mmio_bank: N_IN and N_OUT must not exceed 32");
   end
   if (ranges_overlap(IN_BASE, N_IN, OUT_BASE, OUT_SPAN) ||
       ranges_overlap(IN_BASE, N_IN, RAM_BASE, RAM_SPAN) ||
       ranges_overlap(OUT_BASE, OUT_SPAN, RAM_BASE, RAM_SPAN)) begin : g_map_err
      $error("mmio_bank: input, output and RAM address ranges overlap");
   end

   logic [31:0]       a32;
   logic [N_IN-1:0]   level;
   logic [N_IN-1:0]   pending;
   logic [N_OUT-1:0]  out_hit;
   logic [DATA_W-1:0] regs [N_OUT];

   assign a32     = 32'(addr);
   assign ram_sel = (a32 >= 32'(RAM_BASE));

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      if (EVENT_MASK[i]) begin : g_evt
         mmio_event_capture u_cap (
            .clock   (clock),
            .reset   (reset),
            .raw     (in_data[i*DATA_W]),
            .clr     (wren && wdata[0] && (a32 == 32'(IN_BASE + i))),
            .level   (level[i]),
            .pending (pending[i])
         );
      end else begin : g_plain
         assign level[i]   = 1'b0;
         assign pending[i] = 1'b0;
      end
   end

   always_comb begin
      out_hit = '0;
      for (int j = 0; j < N_OUT; j++) begin
         out_hit[j] = wren && (a32 == 32'(OUT_BASE + j));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < N_OUT; j++) begin
            regs[j] <= OUT_RST;
         end
         out_strobe <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (out_hit[j]) begin
               regs[j] <= wdata;
            end
         end
         out_strobe <= out_hit;
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign out_regs[j*DATA_W +: DATA_W] = regs[j];
   end

`ifdef MMIO_BANK_IRQ_EN
   logic [DATA_W-1:0] irq_en;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq_en <= '0;
         irq    <= 1'b0;
      end else begin
         if (wren && (a32 == 32'(OUT_BASE + N_OUT))) begin
            irq_en <= wdata;
         end
         irq <= |(pending & irq_en[N_IN-1:0]);
      end
   end
`endif

   // Address ranges are disjoint, so only the RAM check needs explicit priority.
   always_comb begin
      rd_data = '0;
      if (ram_sel) begin
         rd_data = ram_rdata;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            if (a32 == 32'(IN_BASE + i)) begin
               if (EVENT_MASK[i]) begin
                  rd_data = DATA_W'({level[i], pending[i]});
               end else begin
                  rd_data = in_data[i*DATA_W +: DATA_W];
               end
            end
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (a32 == 32'(OUT_BASE + j)) begin
               rd_data = regs[j];
            end
         end
`ifdef MMIO_BANK_IRQ_EN
         if (a32 == 32'(OUT_BASE + N_OUT)) begin
            rd_data = irq_en;
         end
`endif
      end
   end

   // Upper bits of event-channel inputs are intentionally ignored.
   logic unused_bits;
`ifdef MMIO_BANK_IRQ_EN
   assign unused_bits = ^{in_data, irq_en};
`else
   assign unused_bits = ^in_data;
`endif

endmodule

// File: tb/tb_mmio_bank.sv
// Directed self-checking bench for mmio_bank (default parameters).
module tb_mmio_bank;

   localparam int DATA_W = 32;
   localparam int N_IN   = 13;
   localparam int N_OUT  = 16;

   logic                    clock;
   logic                    reset;
   logic [11:0]             addr;
   logic                    wren;
   logic [DATA_W-1:0]       wdata;
   logic [DATA_W-1:0]       ram_rdata;
   logic [DATA_W-1:0]       rd_data;
   logic                    ram_sel;
   logic [N_IN*DATA_W-1:0]  in_data;
   logic [N_OUT*DATA_W-1:0] out_regs;
   logic [N_OUT-1:0]        out_strobe;
`ifdef MMIO_BANK_IRQ_EN
   logic                    irq;
`endif

   int passed = 0;
   int total  = 0;

   mmio_bank dut (
      .clock      (clock),
      .reset      (reset),
      .addr       (addr),
      .wren       (wren),
      .wdata      (wdata),
      .ram_rdata  (ram_rdata),
      .rd_data    (rd_data),
      .ram_sel    (ram_sel),
      .in_data    (in_data),
      .out_regs   (out_regs),
`ifdef MMIO_BANK_IRQ_EN
      .irq        (irq),
`endif
      .out_strobe (out_strobe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total++; if (out_regs !== '0) $display("FAIL rst_out_regs got=%h exp=0", out_regs); else passed++;
      total++; if (out_strobe !== '0) $display("FAIL rst_strobe got=%h exp=0", out_strobe); else passed++;
      addr = 12'd18; #1;
      total++; if (rd_data !== 32'h0) $display("FAIL rst_rd18 got=%h exp=0", rd_data); else passed++;
      step(); reset = 1'b0;
      addr = 12'd18; wdata = 32'hAB; wren = 1'b1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'hAB) $display("FAIL wr18 got=%h exp=ab", rd_data); else passed++;
      total++; if (out_strobe !== 16'h0004) $display("FAIL wr18_strobe got=%h exp=0004", out_strobe); else passed++;
      #2 reset = 1'b1;
      #1;
      total++; if (out_regs[2*DATA_W +: DATA_W] !== 32'h0) $display("FAIL midrst_reg2 got=%h exp=0", out_regs[2*DATA_W +: DATA_W]); else passed++;
      total++; if (out_strobe !== '0) $display("FAIL midrst_strobe got=%h exp=0", out_strobe); else passed++;
      total++; if (rd_data !== 32'h0) $display("FAIL midrst_rd18 got=%h exp=0", rd_data); else passed++;
      step(); reset = 1'b0;
   endtask

   task automatic test_reset_held();
      reset = 1'b1;
      in_data[3*DATA_W] = 1'b1;
      addr = 12'd3;
      step(); step();
      reset = 1'b0;
      step();
      total++; if (rd_data !== 32'h0) $display("FAIL held_c1 got=%h exp=0", rd_data); else passed++;
      step();
      total++; if (rd_data !== 32'h2) $display("FAIL held_c2 got=%h exp=2", rd_data); else passed++;
      step();
      total++; if (rd_data !== 32'h3) $display("FAIL held_c3 got=%h exp=3", rd_data); else passed++;
      in_data[3*DATA_W] = 1'b0;
      step(); step(); step();
      total++; if (rd_data !== 32'h1) $display("FAIL held_low got=%h exp=1", rd_data); else passed++;
      wren = 1'b1; wdata = 32'h1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL held_w1c got=%h exp=0", rd_data); else passed++;
   endtask

   task automatic test_out_write();
      addr = 12'd23; wdata = 32'h5; wren = 1'b1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h5) $display("FAIL wr23 got=%h exp=5", rd_data); else passed++;
      total++; if (out_strobe !== 16'h0080) $display("FAIL wr23_strobe got=%h exp=0080", out_strobe); else passed++;
      step();
      total++; if (out_strobe !== 16'h0000) $display("FAIL wr23_strobe_off got=%h exp=0000", out_strobe); else passed++;
      total++; if (out_regs[7*DATA_W +: DATA_W] !== 32'h5) $display("FAIL wr23_reg7 got=%h exp=5", out_regs[7*DATA_W +: DATA_W]); else passed++;
   endtask

   task automatic test_back_to_back();
      addr = 12'd20; wdata = 32'h11; wren = 1'b1;
      step();
      total++; if (out_strobe !== 16'h0010) $display("FAIL b2b_s1 got=%h exp=0010", out_strobe); else passed++;
      total++; if (rd_data !== 32'h11) $display("FAIL b2b_v1 got=%h exp=11", rd_data); else passed++;
      wdata = 32'h22;
      step(); wren = 1'b0;
      total++; if (out_strobe !== 16'h0010) $display("FAIL b2b_s2 got=%h exp=0010", out_strobe); else passed++;
      total++; if (rd_data !== 32'h22) $display("FAIL b2b_v2 got=%h exp=22", rd_data); else passed++;
      step();
      total++; if (out_strobe !== 16'h0000) $display("FAIL b2b_s3 got=%h exp=0000", out_strobe); else passed++;
   endtask

   task automatic test_event();
      addr = 12'd1;
      in_data[1*DATA_W] = 1'b1;
      step(); in_data[1*DATA_W] = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL evt_c1 got=%h exp=0", rd_data); else passed++;
      step();
      total++; if (rd_data !== 32'h2) $display("FAIL evt_c2 got=%h exp=2", rd_data); else passed++;
      step();
      total++; if (rd_data !== 32'h1) $display("FAIL evt_c3 got=%h exp=1", rd_data); else passed++;
      step();
      total++; if (rd_data !== 32'h1) $display("FAIL evt_c4 got=%h exp=1", rd_data); else passed++;
      wren = 1'b1; wdata = 32'h2;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h1) $display("FAIL evt_w0 got=%h exp=1", rd_data); else passed++;
      wren = 1'b1; wdata = 32'h1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL evt_w1c got=%h exp=0", rd_data); else passed++;
   endtask

   task automatic test_set_wins();
      addr = 12'd2;
      in_data[2*DATA_W] = 1'b1;
      step(); in_data[2*DATA_W] = 1'b0;
      step(); step(); step();
      total++; if (rd_data !== 32'h1) $display("FAIL sw_first got=%h exp=1", rd_data); else passed++;
      in_data[2*DATA_W] = 1'b1;
      step(); in_data[2*DATA_W] = 1'b0;
      step();
      wren = 1'b1; wdata = 32'h1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h1) $display("FAIL sw_collide got=%h exp=1", rd_data); else passed++;
      wren = 1'b1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL sw_clear got=%h exp=0", rd_data); else passed++;
   endtask

   task automatic test_ram_unmapped();
      logic [N_OUT*DATA_W-1:0] exp_regs;
      exp_regs = '0;
      exp_regs[7*DATA_W +: DATA_W] = 32'h5;
      exp_regs[4*DATA_W +: DATA_W] = 32'h22;
      addr = 12'd100; ram_rdata = 32'hDEADBEEF; #1;
      total++; if (rd_data !== 32'hDEADBEEF) $display("FAIL ram_rd got=%h exp=deadbeef", rd_data); else passed++;
      total++; if (ram_sel !== 1'b1) $display("FAIL ram_sel got=%b exp=1", ram_sel); else passed++;
      addr = 12'd40; #1;
      total++; if (ram_sel !== 1'b0) $display("FAIL ram_sel40 got=%b exp=0", ram_sel); else passed++;
      wren = 1'b1; wdata = 32'hFFFF_FFFF;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL unmap_rd got=%h exp=0", rd_data); else passed++;
      total++; if (out_regs !== exp_regs) $display("FAIL unmap_regs got=%h exp=%h", out_regs, exp_regs); else passed++;
      total++; if (out_strobe !== '0) $display("FAIL unmap_strobe got=%h exp=0", out_strobe); else passed++;
      addr = 12'd100; wren = 1'b1;
      step();
      addr = 12'd0;
      step(); wren = 1'b0;
      total++; if (out_regs !== exp_regs) $display("FAIL ramwr_regs got=%h exp=%h", out_regs, exp_regs); else passed++;
      in_data[0 +: DATA_W] = 32'h1234_5678; #1;
      total++; if (rd_data !== 32'h1234_5678) $display("FAIL plain_rd0 got=%h exp=12345678", rd_data); else passed++;
`ifndef MMIO_BANK_IRQ_EN
      addr = 12'd32; wren = 1'b1; wdata = 32'h3;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h0) $display("FAIL rd32 got=%h exp=0", rd_data); else passed++;
`endif
   endtask

`ifdef MMIO_BANK_IRQ_EN
   task automatic test_irq();
      addr = 12'd32; wdata = 32'h2; wren = 1'b1;
      step(); wren = 1'b0;
      total++; if (rd_data !== 32'h2) $display("FAIL irq_en_rd got=%h exp=2", rd_data); else passed++;
      addr = 12'd1;
      in_data[1*DATA_W] = 1'b1;
      step(); in_data[1*DATA_W] = 1'b0;
      step(); step();
      total++; if (irq !== 1'b0) $display("FAIL irq_c3 got=%b exp=0", irq); else passed++;
      step();
      total++; if (irq !== 1'b1) $display("FAIL irq_c4 got=%b exp=1", irq); else passed++;
      wren = 1'b1; wdata = 32'h1;
      step(); wren = 1'b0;
      total++; if (irq !== 1'b1) $display("FAIL irq_w1c0 got=%b exp=1", irq); else passed++;
      step();
      total++; if (irq !== 1'b0) $display("FAIL irq_w1c1 got=%b exp=0", irq); else passed++;
   endtask
`endif

   initial begin
      reset     = 1'b1;
      addr      = '0;
      wren      = 1'b0;
      wdata     = '0;
      ram_rdata = '0;
      in_data   = '0;
      test_reset();
      test_reset_held();
      test_out_write();
      test_back_to_back();
      test_event();
      test_set_wins();
      test_ram_unmapped();
`ifdef MMIO_BANK_IRQ_EN
      test_irq();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
